// File: rtl/joy_pkg.sv
// Shared definitions for the PmodJSTK SPI reader: FSM states, joystick constants
// and a counter-width helper.
package joy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SS_SETUP,
        SHIFT,
        BYTE_GAP,
        DONE
    } joy_state_e;

    localparam logic [9:0] JOY_CENTER   = 10'd512;
    localparam logic [5:0] JSTK_CMD_LED = 6'b100000;
    localparam int         NUM_BYTES    = 5;

    // Deflection thresholds applied by the cursor-update stage
    localparam logic [9:0] JOY_THRESH_LO = 10'd256;
    localparam logic [9:0] JOY_THRESH_HI = 10'd768;

    function automatic int cnt_w(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Mode-0, MSB-first 8-bit SPI shifter. start begins a byte with SCLK low;
// done is high on the cycle whose clock edge produces the 8th falling SCLK edge.
module spi_byte_xfer
    import joy_pkg::*;
#(
    parameter int HALF_CYC = 50
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int                HALF_W    = cnt_w(HALF_CYC);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_CYC - 1);

    logic              active;
    logic [HALF_W-1:0] half_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sr;
    logic [7:0]        rx_sr;
    logic              half_end;

    assign half_end = active && (half_cnt == HALF_LAST);
    assign done     = half_end && sclk && (bit_cnt == 3'd0);
    assign mosi     = tx_sr[7];
    assign rx_byte  = rx_sr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            active   <= 1'b0;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else if (start) begin
            active   <= 1'b1;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= 3'd7;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                sclk     <= ~sclk;
                if (sclk) begin
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

    // A load on the final falling edge takes priority so the next byte's MSB is ready
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tx_sr <= '0;
        end else if (load) begin
            tx_sr <= tx_byte;
        end else if (half_end && sclk) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (half_end && !sclk) begin
            rx_sr <= {rx_sr[6:0], miso};
        end
    end

endmodule

// File: rtl/joy_spi_reader.sv
// Periodic PmodJSTK poller: sequences five SPI bytes with setup and inter-byte
// gaps, then publishes 10-bit X/Y and buttons with a one-clock sample_valid.
module joy_spi_reader
    import joy_pkg::*;
#(
    parameter int HALF_CYC     = 50,
    parameter int SS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1000,
    parameter int POLL_CYC     = 1000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       sclk,
    output logic       ss_n,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] joy_btn,
    output logic       sample_valid,
    output logic       busy
);

    localparam int WAIT_MAX = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
    localparam int POLL_W   = cnt_w(POLL_CYC);
    localparam int WAIT_W   = cnt_w(WAIT_MAX);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SS_SETUP_CYC - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(BYTE_GAP_CYC - 1);
    localparam logic [2:0]        LAST_BYTE  = 3'(NUM_BYTES - 1);

    joy_state_e        state_q;
    joy_state_e        state_d;
    logic [POLL_W-1:0] poll_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        byte_idx;

    logic       txn_begin;
    logic       xfer_start;
    logic       xfer_load;
    logic       xfer_done;
    logic       commit;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;

    logic [7:0] x_lo;
    logic [1:0] x_hi;
    logic [7:0] y_lo;
    logic [1:0] y_hi;
    logic [2:0] btn_rx;

    spi_byte_xfer #(
        .HALF_CYC (HALF_CYC)
    ) u_xfer (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (xfer_start),
        .load    (xfer_load),
        .tx_byte (tx_byte),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .done    (xfer_done),
        .rx_byte (rx_byte)
    );

    always_comb begin
        state_d    = state_q;
        txn_begin  = 1'b0;
        xfer_start = 1'b0;
        xfer_load  = 1'b0;
        tx_byte    = 8'h00;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                // led is captured here via the shifter load; later changes wait a poll
                if (poll_cnt == POLL_LAST) begin
                    state_d   = SS_SETUP;
                    txn_begin = 1'b1;
                    xfer_load = 1'b1;
                    tx_byte   = {JSTK_CMD_LED, led};
                end
            end
            SS_SETUP: begin
                if (wait_cnt == SETUP_LAST) begin
                    state_d    = SHIFT;
                    xfer_start = 1'b1;
                end
            end
            SHIFT: begin
                if (xfer_done) begin
                    xfer_load = 1'b1;
                    state_d   = (byte_idx == LAST_BYTE) ? DONE : BYTE_GAP;
                end
            end
            BYTE_GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    state_d    = SHIFT;
                    xfer_start = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                commit  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= IDLE;
            poll_cnt     <= '0;
            wait_cnt     <= '0;
            byte_idx     <= 3'd0;
            ss_n         <= 1'b1;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            joy_x        <= JOY_CENTER;
            joy_y        <= JOY_CENTER;
            joy_btn      <= 3'd0;
        end else begin
            state_q      <= state_d;
            sample_valid <= commit;

            if ((state_q == IDLE) && !txn_begin) begin
                poll_cnt <= poll_cnt + 1'b1;
            end else begin
                poll_cnt <= '0;
            end

            if ((state_d == state_q) && ((state_q == SS_SETUP) || (state_q == BYTE_GAP))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (txn_begin) begin
                ss_n     <= 1'b0;
                busy     <= 1'b1;
                byte_idx <= 3'd0;
            end else if (xfer_done) begin
                byte_idx <= byte_idx + 3'd1;
            end

            if (commit) begin
                ss_n    <= 1'b1;
                busy    <= 1'b0;
                joy_x   <= {x_hi, x_lo};
                joy_y   <= {y_hi, y_lo};
                joy_btn <= btn_rx;
            end
        end
    end

    // Received bytes are only published on commit, so an aborted read leaves outputs intact
    always_ff @(posedge clk) begin
        if (xfer_done) begin
            case (byte_idx)
                3'd0:    x_lo   <= rx_byte;
                3'd1:    x_hi   <= rx_byte[1:0];
                3'd2:    y_lo   <= rx_byte;
                3'd3:    y_hi   <= rx_byte[1:0];
                default: btn_rx <= rx_byte[2:0];
            endcase
        end
    end

endmodule

// File: tb/tb_joy_spi_reader.sv
// Scoreboard bench for joy_spi_reader with a PmodJSTK slave model and
// randomized joystick data.
module tb_joy_spi_reader;

    localparam int HALF    = 2;
    localparam int SETUP   = 4;
    localparam int GAP     = 3;
    localparam int POLL    = 50;
    localparam int TXN_LEN = SETUP + 80 * HALF + 4 * GAP + 1;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [1:0] led;
    logic       miso;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic [9:0] joy_x;
    logic [9:0] joy_y;
    logic [2:0] joy_btn;
    logic       sample_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_sv_cyc = -1;

    logic [39:0] slave_q[$];
    exp_t        exp_q[$];

    joy_spi_reader #(
        .HALF_CYC     (HALF),
        .SS_SETUP_CYC (SETUP),
        .BYTE_GAP_CYC (GAP),
        .POLL_CYC     (POLL)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .led          (led),
        .miso         (miso),
        .sclk         (sclk),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .joy_x        (joy_x),
        .joy_y        (joy_y),
        .joy_btn      (joy_btn),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: X/Y are a 10-bit value split across a low byte and two high bits
    function automatic exp_t model(input logic [39:0] d);
        exp_t r;
        int   b0, b1, b2, b3, b4;
        b0 = int'(d[39:32]);
        b1 = int'(d[31:24]);
        b2 = int'(d[23:16]);
        b3 = int'(d[15:8]);
        b4 = int'(d[7:0]);
        r.x   = 10'((b1 % 4) * 256 + b0);
        r.y   = 10'((b3 % 4) * 256 + b2);
        r.btn = 3'(b4 % 8);
        return r;
    endfunction

    task automatic check_reset_vals();
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_mosi", mosi, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_joy_x", joy_x, 512);
        check("rst_joy_y", joy_y, 512);
        check("rst_joy_btn", joy_btn, 0);
    endtask

    task automatic release_and_check_poll();
        int bad = 0;
        @(negedge clk);
        clr_n = 1'b1;
        last_sv_cyc = -1;
        for (int i = 1; i <= POLL; i++) begin
            @(negedge clk);
            if (i < POLL) begin
                if (ss_n !== 1'b1 || sample_valid !== 1'b0 || joy_x !== 10'd512 ||
                    joy_y !== 10'd512 || joy_btn !== 3'd0) bad++;
            end
        end
        check("idle_before_poll", bad, 0);
        check("ss_fall_at_poll", ss_n, 0);
    endtask

    task automatic wait_busy(input logic v, input int lim);
        int n = 0;
        while (busy !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy", busy, v);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while ((slave_q.size() != 0 || exp_q.size() != 0 || busy !== 1'b0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", slave_q.size() + exp_q.size(), 0);
    endtask

    // Slave: presents MSB at ss_n fall, shifts on SCLK fall, captures MOSI on SCLK rise
    initial begin
        logic        prev_ss, prev_sclk, prev_mosi, rise_bit, active, ok;
        logic [39:0] data, cap;
        logic [1:0]  led_at_start;
        int          bitn, rises, len;
        prev_ss = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; rise_bit = 1'b0;
        active = 1'b0; ok = 1'b1; data = '0; cap = '0; led_at_start = 2'b00;
        bitn = 0; rises = 0; len = 0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ss && !ss_n && clr_n) begin
                active = 1'b1; bitn = 0; rises = 0; len = 0; ok = 1'b1; cap = '0;
                led_at_start = led;
                if (slave_q.size() > 0) data = slave_q.pop_front();
                else data = {32'($urandom()), 8'($urandom())};
                exp_q.push_back(model(data));
                miso = data[39];
            end
            if (active) begin
                if (!ss_n) len++;
                if (sclk && !prev_sclk) begin
                    rises++;
                    cap = {cap[38:0], mosi};
                    rise_bit = mosi;
                    if (mosi !== prev_mosi) ok = 1'b0;
                end else if (sclk && prev_sclk) begin
                    if (mosi !== rise_bit) ok = 1'b0;
                end
                if (!sclk && prev_sclk) begin
                    bitn++;
                    miso = (bitn < 40) ? data[39 - bitn] : 1'b0;
                end
                if (ss_n) begin
                    active = 1'b0;
                    if (!clr_n) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_back());
                    end else begin
                        check("slave_mosi_bytes", cap, {6'b100000, led_at_start, 32'h0});
                        check("sclk_rises", rises, 40);
                        check("mosi_stable", ok, 1);
                        check("ss_low_len", len, TXN_LEN);
                    end
                end
            end
            prev_ss = ss_n; prev_sclk = sclk; prev_mosi = mosi;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a sample
    initial begin
        logic prev_sv;
        exp_t e;
        prev_sv = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_n && sample_valid) begin
                check("sv_single_clock", prev_sv, 0);
                check("sample_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("joy_x", joy_x, e.x);
                    check("joy_y", joy_y, e.y);
                    check("joy_btn", joy_btn, e.btn);
                end
                if (last_sv_cyc >= 0) check("sample_spacing", cyc - last_sv_cyc, TXN_LEN + POLL);
                last_sv_cyc = cyc;
            end
            prev_sv = sample_valid;
        end
    end

    initial begin
        logic [39:0] d;
        clr_n = 1'b1;
        led   = 2'b10;
        slave_q.push_back(40'hA5_FE_3C_01_05);
        #2 clr_n = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(negedge clk);
        release_and_check_poll();
        wait_done(3000);

        // Alternating full-scale X, with random don't-care bits above X[9:8]
        for (int i = 0; i < 4; i++) begin
            d[39:32] = (i % 2 == 1) ? 8'hFF : 8'h00;
            d[31:24] = {6'($urandom()), (i % 2 == 1) ? 2'b11 : 2'b00};
            d[23:0]  = 24'($urandom());
            slave_q.push_back(d);
        end
        wait_done(3000);

        #2 led = 2'b01;
        wait_busy(1'b1, 400);
        repeat (20) @(negedge clk);
        #2 led = 2'b11;
        wait_busy(1'b0, 400);
        wait_busy(1'b1, 400);
        wait_busy(1'b0, 400);
        wait_done(3000);

        for (int i = 0; i < 3; i++) begin
            #2 led = 2'($urandom());
            slave_q.push_back({32'($urandom()), 8'($urandom())});
            wait_done(1500);
        end

        // Abort in the middle of byte 2
        wait_busy(1'b1, 400);
        repeat (80) @(negedge clk);
        #2 clr_n = 1'b0;
        #1 check_reset_vals();
        slave_q.push_back(40'h7F_02_80_03_02);
        repeat (3) @(negedge clk);
        release_and_check_poll();
        wait_done(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
